// File: rtl/piso_rr_serializer.sv
// Round-robin arbiter feeding an LSB-first serializer with frame qualifiers
// and a fixed idle gap after every frame.

module piso_rr_lane #(
  parameter int SRC_W = 2,
  parameter int IDX   = 0
) (
  input  logic             grant_en,
  input  logic [SRC_W-1:0] winner,
  output logic             ready
);
  assign ready = grant_en && (winner == SRC_W'(IDX));
endmodule

module piso_rr_serializer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  parameter  int GAP        = 2,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          dout_last,
  output logic [SRC_W-1:0]              dout_src,
  output logic                          busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH+1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP+1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                             state;
  logic [DATA_WIDTH-1:0]              sr;
  logic [CNT_W-1:0]                   bit_cnt;
  logic [GAP_W-1:0]                   gap_cnt;
  logic [SRC_W-1:0]                   src, ptr, ptr_nxt, winner, cand;
  logic                               found, grant_en;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_word;
  int                                 idx;

  assign req_word = req_data;

  // Search starts at ptr and wraps explicitly so NUM_REQ need not be 2^n.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = SRC_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_en = (state == S_IDLE) && found && !flush && resetn;
  assign ptr_nxt  = (winner == SRC_W'(NUM_REQ-1)) ? '0 : winner + SRC_W'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    piso_rr_lane #(.SRC_W(SRC_W), .IDX(i)) u_lane (
      .grant_en (grant_en),
      .winner   (winner),
      .ready    (req_ready[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      src        <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
    end else if (flush) begin
      // ptr is left alone: a flushed grant still used up that requester's turn.
      state      <= S_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            sr         <= req_word[winner];
            src        <= winner;
            bit_cnt    <= '0;
            ptr        <= ptr_nxt;
            state      <= S_SHIFT;
            dout_valid <= 1'b1;
            dout_last  <= (DATA_WIDTH == 1);
            busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          sr      <= sr >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_CNT) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            gap_cnt    <= '0;
            if (GAP > 0) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dout_last <= (int'(bit_cnt) == DATA_WIDTH-2);
          end
        end
        S_GAP: begin
          if (int'(gap_cnt) == GAP-1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // sr is zero outside SHIFT (zero fill, flush and reset clear it).
  assign dout     = sr[0];
  assign dout_src = src;

endmodule
